// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } dcache_state_e;

  localparam int DEF_INDEX_BITS = 3;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int DEF_LINES     = 1 << DEF_INDEX_BITS;
  localparam int DEF_TAG_BITS  = DEF_ADDR_WIDTH - DEF_INDEX_BITS - 2;

  function automatic int tag_bits(input int addr_width, input int index_bits);
    return addr_width - index_bits - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup port, one synchronous write port.
module dcache_array #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 27,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_set_valid
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we && i_set_valid) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data carry no reset; the valid bits mask whatever they hold.
  always_ff @(posedge clk) begin
    if (i_we && !rst) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line data cache controller: zero-wait load hits,
// blocking load-miss fill, write-through no-write-allocate stores.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS);

  dcache_state_e r_state, w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;

  logic [INDEX_BITS-1:0] w_cpu_index, w_lat_index;
  logic [TAG_BITS-1:0]   w_cpu_tag, w_lat_tag;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_arr_data;

  logic                  w_arr_we;
  logic [INDEX_BITS-1:0] w_arr_index;
  logic [TAG_BITS-1:0]   w_arr_tag;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic                  w_arr_set_valid;
  logic                  w_latch;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_unused_addr_lsb;

  assign w_cpu_index       = cpu_addr[INDEX_BITS+1:2];
  assign w_cpu_tag         = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_lat_index       = r_addr[INDEX_BITS+1:2];
  assign w_lat_tag         = r_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_unused_addr_lsb = ^{cpu_addr[1:0], r_addr[1:0]};

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_index  (w_cpu_index),
    .i_rd_tag    (w_cpu_tag),
    .o_hit       (w_hit),
    .o_rd_data   (w_arr_data),
    .i_we        (w_arr_we),
    .i_wr_index  (w_arr_index),
    .i_wr_tag    (w_arr_tag),
    .i_wr_data   (w_arr_wdata),
    .i_set_valid (w_arr_set_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        if (cpu_we) r_wdata <= cpu_wdata;
      end
      if (w_hit_inc && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_miss_inc && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    cpu_stall       = 1'b0;
    cpu_rdata       = w_arr_data;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = r_addr;
    mem_wdata       = r_wdata;
    w_arr_we        = 1'b0;
    w_arr_index     = w_cpu_index;
    w_arr_tag       = w_cpu_tag;
    w_arr_wdata     = cpu_wdata;
    w_arr_set_valid = 1'b0;
    w_latch         = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (!cpu_we) begin
            if (w_hit) begin
              w_hit_inc = 1'b1;
            end else begin
              cpu_stall    = 1'b1;
              w_latch      = 1'b1;
              w_miss_inc   = 1'b1;
              w_next_state = RD_MISS;
            end
          end else begin
            // Store hit updates the line now; a store miss leaves the array alone.
            cpu_stall    = 1'b1;
            w_latch      = 1'b1;
            w_arr_we     = w_hit;
            w_next_state = WR_THRU;
          end
        end
      end

      RD_MISS: begin
        mem_req   = 1'b1;
        cpu_stall = !mem_ready;
        if (mem_ready) begin
          cpu_rdata       = mem_rdata;
          w_arr_we        = 1'b1;
          w_arr_index     = w_lat_index;
          w_arr_tag       = w_lat_tag;
          w_arr_wdata     = mem_rdata;
          w_arr_set_valid = 1'b1;
          w_next_state    = IDLE;
        end
      end

      WR_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_stall = !mem_ready;
        if (mem_ready) w_next_state = IDLE;
      end

      default: w_next_state = IDLE;
    endcase
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed cases plus random traffic
// against a behavioural cache/memory model.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: per-line valid/tag/data, a sparse main memory, counters.
  logic        m_valid [8];
  logic [26:0] m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] m_mem   [int unsigned];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic chk_counters();
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
  endtask

  // One complete CPU access; the memory answers n cycles after mem_req rises.
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int n);
    int          idx;
    logic [26:0] tg;
    logic        hit;
    logic [31:0] waddr;
    logic [31:0] rd;
    int          stalls;
    idx   = int'(addr[4:2]);
    tg    = addr[31:5];
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    waddr = {addr[31:2], 2'b00};

    @(posedge clk); #1;
    chk_counters();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #2;
    chk("idle_mem_req", mem_req, 0);
    if (!we && hit) begin
      chk("hit_stall", cpu_stall, 0);
      chk("hit_rdata", cpu_rdata, m_data[idx]);
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      chk("req_stall", cpu_stall, 1);
      stalls = int'(cpu_stall);
      if (!we && m_misses != 32'hFFFF_FFFF) m_misses++;
      for (int k = 0; k <= n; k++) begin
        @(posedge clk); #1;
        mem_ready = (k == n);
        rd        = we ? $urandom : mem_rd(waddr);
        mem_rdata = rd;
        #2;
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, waddr);
        if (we) chk("mem_wdata", mem_wdata, wdata);
        chk("xfer_stall", cpu_stall, (k != n));
        stalls += int'(cpu_stall);
        if (!we && k == n) chk("miss_rdata", cpu_rdata, rd);
      end
      chk("stall_cycles", stalls, n + 1);
      if (we) begin
        m_mem[waddr] = wdata;
        if (hit) m_data[idx] = wdata;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = rd;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk_counters();
    cpu_req   = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #2;
    chk("idle_stall", cpu_stall, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    logic [31:0] a;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    m_mem[32'h0000_0104] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk_counters();

    // Cold miss, hits, conflict miss, refill.
    access(1'b0, 32'h0000_0104, '0, 3);
    access(1'b0, 32'h0000_0104, '0, 0);
    access(1'b0, 32'h0000_0107, '0, 0);
    access(1'b0, 32'h0000_0124, '0, 2);
    access(1'b0, 32'h0000_0104, '0, 1);
    // Store hit, then load sees new data from the cache.
    access(1'b1, 32'h0000_0104, 32'h1234_5678, 2);
    access(1'b0, 32'h0000_0104, '0, 0);
    // Store miss does not allocate.
    access(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1);
    access(1'b0, 32'h0000_0200, '0, 1);
    // Immediate memory response: exactly one stall cycle.
    access(1'b0, 32'h0000_0414, '0, 0);
    access(1'b1, 32'h0000_0418, 32'h0BAD_F00D, 0);
    idle_cycle();

    // Reset in the second RD_MISS cycle, late ready afterwards.
    @(posedge clk); #1;
    chk_counters();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0340;
    mem_ready = 1'b0;
    #2;
    chk("rm_stall0", cpu_stall, 1);
    @(posedge clk); #1;
    #2;
    chk("rm_mem_req1", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("rm_mem_req2", mem_req, 1);
    chk("rm_stall2", cpu_stall, 1);
    @(posedge clk); #1;
    rst       = 1'b0;
    cpu_req   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #2;
    model_reset();
    chk("post_rst_mem_req", mem_req, 0);
    chk("post_rst_mem_we", mem_we, 0);
    chk("post_rst_stall", cpu_stall, 0);
    chk_counters();
    access(1'b0, 32'h0000_0340, '0, 1);
    access(1'b0, 32'h0000_0104, '0, 2);
    access(1'b0, 32'h0000_0340, '0, 0);

    // Random traffic over a small address footprint to mix hits and misses.
    for (int t = 0; t < 200; t++) begin
      a = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      access(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
